regfile_multiport_sb: RTL and testbench
=======================================

Name: regfile_multiport_sb

Overview:
- Parametrised successor to the single-write integer register file.
- Provides NUM_READ combinational read ports and NUM_WRITE write ports, with write-to-read bypass.
- Supports an optional hardwired-zero register 0 and a per-register busy scoreboard for in-flight producers.
- After reset, a sweep FSM clears the array one entry per cycle. It sits between decode/issue (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 2, number of write ports (1..2).
- HARDWIRE_ZERO, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_index  in  NUM_READ*ADDR_WIDTH  read indices; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rs_data  out  NUM_READ*XLEN  read data, packed the same way.
- rs_busy  out  NUM_READ  scoreboard busy flag per read port.
- wr_en  in  NUM_WRITE  write enable per port.
- wr_index  in  NUM_WRITE*ADDR_WIDTH  write indices.
- wr_data  in  NUM_WRITE*XLEN  write data.
- issue_en  in  1  mark issue_index busy (new producer issued).
- issue_index  in  ADDR_WIDTH  destination being issued.
- init_done  out  1  high once the clear sweep is complete.

Behaviour:
FSM states:
- INIT: entered on any cycle with reset=1, including mid-operation.
  - Sweep counter resets to 0. Each cycle with reset=0 clears registers[cnt] and increments cnt.
  - After entry 2**ADDR_WIDTH-1 is cleared, go to RUN on the next edge.
  - Total sweep = 2**ADDR_WIDTH cycles after reset deasserts.
- RUN: normal operation; terminal until the next reset.

Reset values and INIT-state behaviour:
- reset=1 clears all busy bits, init_done=0, state=INIT, cnt=0.
- In INIT: init_done=0, rs_data=0, rs_busy=0, wr_en and issue_en ignored.
- init_done is registered: 1 exactly from the first RUN cycle.

Writes (RUN):
- Port w with wr_en[w]=1 updates registers[wr_index[w]] at the edge.
- Same-cycle, same-index collision across ports: the highest-numbered port wins.
- HARDWIRE_ZERO=1: writes to index 0 are dropped.

Reads (RUN):
- Combinational, zero latency.
- Bypass: if any enabled write in the same cycle targets rs_index[p], rs_data[p] returns that write data (highest port wins); otherwise the array value.
- HARDWIRE_ZERO=1 and index 0: rs_data=0 regardless of bypass.

Scoreboard (RUN):
- busy[issue_index] set at the edge when issue_en=1.
- busy[wr_index[w]] cleared at the edge when wr_en[w]=1.
- Issue and write to the same index in the same cycle: set wins (the new producer supersedes).
- rs_busy[p] = busy[rs_index[p]] AND NOT (same-cycle enabled write to that index AND NOT same-cycle issue to that index).
- Index 0 is never busy when HARDWIRE_ZERO=1.

Boundary conditions:
- All read ports may alias the same index.
- Writing an already-idle register is legal; busy stays 0.
- Issue to an already-busy register keeps it busy.
- Reset asserted during INIT restarts the sweep from 0.

Decomposition:
- Shared package regfile_pkg: typedef reg_index_t (ADDR_WIDTH bits), typedef xlen_t (XLEN bits), constants REG_DEPTH = 2**ADDR_WIDTH and ZERO_REG = 0, and enum rf_state_t {RF_INIT, RF_RUN}.
- One natural sub-module, regfile_scoreboard: busy-bit array with set/clear priority and the per-port rs_busy lookup.
- Array, bypass muxing and sweep FSM stay in the top.

Test Plan:
- Reset sweep: assert reset 2 cycles, deassert → init_done=0 for exactly 32 cycles, then 1. Reads during INIT return 0. A write of 0xDEAD to r5 issued during INIT is ignored (r5 reads 0 in RUN).
- Basic write/read: write r3=0x1234 (port 0), next cycle rs_index[0]=3 → 0x1234. Same-cycle write r7=0xABCD with rs_index[1]=7 → bypass returns 0xABCD that cycle.
- Collision: port0 r9=0x1111 and port1 r9=0x2222 in the same cycle → r9 reads 0x2222 afterwards, and the bypass also shows 0x2222.
- Zero register: write r0=0xFFFFFFFF, issue r0 → r0 reads 0 and rs_busy=0. With HARDWIRE_ZERO=0 build, r0 reads 0xFFFFFFFF.
- Scoreboard: issue r4 → rs_busy=1 next cycle. Write r4 → rs_busy=0 in the write cycle (bypass) and after. Same-cycle issue r4 + write r4 → busy stays 1 and the data updates.
- Mid-operation reset: busy r10 set and r10=0x55; assert reset 1 cycle → busy cleared, init_done=0. After the sweep, r10 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int REG_DEPTH      = 2**ADDR_WIDTH_DEF;
  localparam int ZERO_REG       = 0;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_index_t;
  typedef logic [XLEN_DEF-1:0]       xlen_t;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight producers: set on issue, cleared on writeback,
// with a same-cycle lookup that accounts for a write landing in the current cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH    = $clog2(REG_DEPTH),
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 2,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WRITE-1:0]          wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_index,
  input  logic                          issue_en,
  input  logic [ADDR_WIDTH-1:0]         issue_index,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rs_index,
  output logic [NUM_READ-1:0]           rs_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // NOTE: combinational blocks use blocking assignments and start from a full default,
  // so later statements override earlier ones and no latch can be inferred.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en[w]) busy_d[wr_index[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    // A new producer supersedes the write that retires the old one.
    if (issue_en) busy_d[issue_index] = 1'b1;
    if (HARDWIRE_ZERO != 0) busy_d[ZERO_REG] = 1'b0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] idx;
    logic                  wr_hit;
    logic                  iss_hit;
    rs_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      idx    = rs_index[p*ADDR_WIDTH +: ADDR_WIDTH];
      wr_hit = 1'b0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (wr_index[w*ADDR_WIDTH +: ADDR_WIDTH] == idx)) wr_hit = 1'b1;
      end
      iss_hit    = issue_en && (issue_index == idx);
      rs_busy[p] = busy_q[idx] && !(wr_hit && !iss_hit);
      if ((HARDWIRE_ZERO != 0) && (idx == ADDR_WIDTH'(ZERO_REG))) rs_busy[p] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_multiport_sb.sv
// Multi-port register file with write-to-read bypass, optional hardwired r0,
// busy scoreboard, and a post-reset sweep that clears one entry per cycle.
module regfile_multiport_sb
  import regfile_pkg::*;
#(
  parameter int XLEN          = $bits(xlen_t),
  parameter int ADDR_WIDTH    = $clog2(REG_DEPTH),
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 2,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rs_index,
  output logic [NUM_READ*XLEN-1:0]        rs_data,
  output logic [NUM_READ-1:0]             rs_busy,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_index,
  input  logic [NUM_WRITE*XLEN-1:0]       wr_data,
  input  logic                            issue_en,
  input  logic [ADDR_WIDTH-1:0]           issue_index,
  output logic                            init_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [XLEN-1:0]       regs_q [DEPTH];
  rf_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q;
  logic                  run;
  logic [NUM_WRITE-1:0]  wr_en_act;
  logic                  issue_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RF_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == RF_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_WIDTH'(DEPTH-1)) state_d = RF_RUN;
    end
  end

  always_comb begin
    run       = (state_q == RF_RUN);
    wr_en_act = run ? wr_en : '0;
    issue_act = run && issue_en;
  end

  assign init_done = init_done_q;

  // NOTE: the array has no reset branch; it is cleared by the sweep so it can map to RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == RF_INIT) begin
        regs_q[cnt_q] <= '0;
      end else begin
        // Later ports override earlier ones, so the highest-numbered port wins a collision.
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_en_act[w] && !((HARDWIRE_ZERO != 0) &&
              (wr_index[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_REG)))) begin
            regs_q[wr_index[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] idx;
    logic [XLEN-1:0]       data;
    rs_data = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      idx  = rs_index[p*ADDR_WIDTH +: ADDR_WIDTH];
      data = regs_q[idx];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en_act[w] && (wr_index[w*ADDR_WIDTH +: ADDR_WIDTH] == idx)) begin
          data = wr_data[w*XLEN +: XLEN];
        end
      end
      if ((HARDWIRE_ZERO != 0) && (idx == ADDR_WIDTH'(ZERO_REG))) data = '0;
      if (!run) data = '0;
      rs_data[p*XLEN +: XLEN] = data;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_READ      (NUM_READ),
    .NUM_WRITE     (NUM_WRITE),
    .HARDWIRE_ZERO (HARDWIRE_ZERO)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en_act),
    .wr_index    (wr_index),
    .issue_en    (issue_act),
    .issue_index (issue_index),
    .rs_index    (rs_index),
    .rs_busy     (rs_busy)
  );

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Scoreboard-driven bench for regfile_multiport_sb: a hardwired-zero instance and a
// plain-r0 instance share stimulus; expected outputs are queued and checked each cycle.
module tb_regfile_multiport_sb;
  import regfile_pkg::*;

  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rs_index;
  logic [NR*XL-1:0] rs_data, nz_rs_data;
  logic [NR-1:0]    rs_busy, nz_rs_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_index;
  logic [NW*XL-1:0] wr_data;
  logic             issue_en;
  reg_index_t       issue_index;
  logic             init_done, nz_init_done;

  typedef enum {S_RS0, S_RS1, S_BUSY0, S_BUSY1, S_DONE, S_NZ_RS0, S_NZ_BUSY0, S_NZ_DONE} sel_e;
  typedef struct {
    sel_e  sel;
    string tag;
    xlen_t val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_multiport_sb #(.XLEN(XL), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW),
                         .HARDWIRE_ZERO(1)) dut (
    .clk(clk), .reset(reset), .rs_index(rs_index), .rs_data(rs_data), .rs_busy(rs_busy),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .issue_en(issue_en),
    .issue_index(issue_index), .init_done(init_done)
  );

  regfile_multiport_sb #(.XLEN(XL), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW),
                         .HARDWIRE_ZERO(0)) dut_nz (
    .clk(clk), .reset(reset), .rs_index(rs_index), .rs_data(nz_rs_data), .rs_busy(nz_rs_busy),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .issue_en(issue_en),
    .issue_index(issue_index), .init_done(nz_init_done)
  );

  task automatic check(input string tag, input xlen_t act, input xlen_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input sel_e sel, input string tag, input xlen_t val);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic xlen_t observe(input sel_e sel);
    case (sel)
      S_RS0:      return rs_data[0 +: XL];
      S_RS1:      return rs_data[XL +: XL];
      S_BUSY0:    return xlen_t'(rs_busy[0]);
      S_BUSY1:    return xlen_t'(rs_busy[1]);
      S_DONE:     return xlen_t'(init_done);
      S_NZ_RS0:   return nz_rs_data[0 +: XL];
      S_NZ_BUSY0: return xlen_t'(nz_rs_busy[0]);
      S_NZ_DONE:  return xlen_t'(nz_init_done);
      default:    return 'x;
    endcase
  endfunction

  task automatic idle();
    rs_index    = '0;
    wr_en       = '0;
    wr_index    = '0;
    wr_data     = '0;
    issue_en    = 1'b0;
    issue_index = '0;
  endtask

  task automatic set_rd(input int p, input int idx);
    rs_index[p*AW +: AW] = AW'(idx);
  endtask

  task automatic write(input int w, input int idx, input xlen_t data);
    wr_en[w]             = 1'b1;
    wr_index[w*AW +: AW] = AW'(idx);
    wr_data[w*XL +: XL]  = data;
  endtask

  task automatic issue(input int idx);
    issue_en    = 1'b1;
    issue_index = AW'(idx);
  endtask

  // Sample at the falling edge, drain the expectation queue, then advance past the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sweep_cycles(input int n, input bit inject);
    for (int i = 0; i < n; i++) begin
      set_rd(0, 5);
      set_rd(1, i);
      if (inject && i == 3) begin
        write(0, 5, 32'h0000_DEAD);
        issue(5);
      end
      expect_out(S_DONE,    "sweep_done",    0);
      expect_out(S_NZ_DONE, "sweep_nz_done", 0);
      expect_out(S_RS0,     "sweep_rs0",     0);
      expect_out(S_RS1,     "sweep_rs1",     0);
      expect_out(S_BUSY0,   "sweep_busy0",   0);
      expect_out(S_NZ_RS0,  "sweep_nz_rs0",  0);
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_out(S_DONE,  "reset_done",  0);
    expect_out(S_RS0,   "reset_rs0",   0);
    expect_out(S_BUSY0, "reset_busy0", 0);
    cycle();
    expect_out(S_DONE, "reset_done2", 0);
    cycle();
    reset = 1'b0;

    // Exactly 2**AW low cycles, with a write and issue to r5 that must be ignored.
    sweep_cycles(32, 1'b1);
    set_rd(0, 5);
    expect_out(S_DONE,    "sweep_end_done",    1);
    expect_out(S_NZ_DONE, "sweep_end_nz_done", 1);
    expect_out(S_RS0,     "init_write_ignored", 0);
    expect_out(S_BUSY0,   "init_issue_ignored", 0);
    cycle();

    // Basic write then read, and same-cycle bypass on port 1.
    write(0, 3, 32'h0000_1234);
    write(1, 7, 32'h0000_ABCD);
    set_rd(0, 3);
    set_rd(1, 7);
    expect_out(S_RS0, "bypass_r3", 32'h0000_1234);
    expect_out(S_RS1, "bypass_r7", 32'h0000_ABCD);
    cycle();
    set_rd(0, 3);
    set_rd(1, 7);
    expect_out(S_RS0, "read_r3", 32'h0000_1234);
    expect_out(S_RS1, "read_r7", 32'h0000_ABCD);
    cycle();

    // Collision: port 1 wins both in the array and on the bypass path.
    write(0, 9, 32'h0000_1111);
    write(1, 9, 32'h0000_2222);
    set_rd(0, 9);
    set_rd(1, 9);
    expect_out(S_RS0, "collide_bypass0", 32'h0000_2222);
    expect_out(S_RS1, "collide_bypass1", 32'h0000_2222);
    cycle();
    set_rd(0, 9);
    expect_out(S_RS0,    "collide_read",    32'h0000_2222);
    expect_out(S_NZ_RS0, "collide_nz_read", 32'h0000_2222);
    cycle();

    // Register 0: hardwired instance reads zero and never busy; plain instance stores it.
    write(0, 0, 32'hFFFF_FFFF);
    issue(0);
    set_rd(0, 0);
    expect_out(S_RS0,      "r0_bypass",       0);
    expect_out(S_BUSY0,    "r0_busy_now",     0);
    expect_out(S_NZ_RS0,   "nz_r0_bypass",    32'hFFFF_FFFF);
    expect_out(S_NZ_BUSY0, "nz_r0_busy_now",  0);
    cycle();
    set_rd(0, 0);
    expect_out(S_RS0,      "r0_read",         0);
    expect_out(S_BUSY0,    "r0_busy",         0);
    expect_out(S_NZ_RS0,   "nz_r0_read",      32'hFFFF_FFFF);
    expect_out(S_NZ_BUSY0, "nz_r0_busy",      1);
    cycle();

    // Scoreboard on r4.
    issue(4);
    set_rd(0, 4);
    expect_out(S_BUSY0, "issue_same_cycle", 0);
    cycle();
    issue(4);
    set_rd(0, 4);
    expect_out(S_BUSY0, "issue_next_cycle", 1);
    cycle();
    set_rd(0, 4);
    expect_out(S_BUSY0, "reissue_keeps_busy", 1);
    cycle();
    write(1, 4, 32'h0000_4444);
    set_rd(0, 4);
    expect_out(S_BUSY0, "wb_clears_now", 0);
    expect_out(S_RS0,   "wb_bypass",     32'h0000_4444);
    cycle();
    write(0, 4, 32'h0000_4545);
    set_rd(0, 4);
    expect_out(S_BUSY0, "wb_cleared",     0);
    expect_out(S_RS0,   "idle_wr_bypass", 32'h0000_4545);
    cycle();
    set_rd(0, 4);
    expect_out(S_BUSY0, "idle_wr_busy", 0);
    expect_out(S_RS0,   "idle_wr_data", 32'h0000_4545);
    cycle();
    issue(4);
    write(0, 4, 32'h0000_5555);
    set_rd(0, 4);
    expect_out(S_BUSY0, "iss_wr_idle_now", 0);
    expect_out(S_RS0,   "iss_wr_bypass",   32'h0000_5555);
    cycle();
    set_rd(0, 4);
    set_rd(1, 4);
    expect_out(S_BUSY0, "iss_wr_set_wins0", 1);
    expect_out(S_BUSY1, "iss_wr_set_wins1", 1);
    expect_out(S_RS0,   "alias_rs0",        32'h0000_5555);
    expect_out(S_RS1,   "alias_rs1",        32'h0000_5555);
    cycle();
    issue(4);
    write(1, 4, 32'h0000_6666);
    set_rd(0, 4);
    expect_out(S_BUSY0, "iss_wr_busy_now", 1);
    expect_out(S_RS0,   "iss_wr_busy_byp", 32'h0000_6666);
    cycle();
    set_rd(0, 4);
    expect_out(S_BUSY0, "iss_wr_busy_after", 1);
    expect_out(S_RS0,   "iss_wr_busy_data",  32'h0000_6666);
    cycle();

    // Mid-operation reset, then a reset during the sweep that must restart it.
    write(0, 10, 32'h0000_0055);
    cycle();
    issue(10);
    cycle();
    set_rd(1, 10);
    expect_out(S_BUSY1, "r10_busy", 1);
    expect_out(S_RS1,   "r10_data", 32'h0000_0055);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_rd(1, 10);
    expect_out(S_DONE,  "midrst_done",  0);
    expect_out(S_BUSY1, "midrst_busy",  0);
    cycle();
    sweep_cycles(9, 1'b0);
    reset = 1'b1;
    expect_out(S_DONE, "restart_done", 0);
    cycle();
    reset = 1'b0;
    sweep_cycles(32, 1'b0);
    set_rd(0, 5);
    set_rd(1, 10);
    expect_out(S_DONE,    "resweep_done",    1);
    expect_out(S_NZ_DONE, "resweep_nz_done", 1);
    expect_out(S_RS1,     "r10_cleared",     0);
    expect_out(S_BUSY1,   "r10_not_busy",    0);
    expect_out(S_RS0,     "r5_cleared",      0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
